// File: rtl/game_event_scheduler.sv
// game_event_scheduler: merges key strobes and timed gravity ticks into a FIFO for the game logic.
// Optional EVENT_SCHED_DOWN_RESYNC_EN: an accepted key EV_DOWN also restarts the gravity interval.
`ifndef EV_LEFT
`define EV_LEFT   3'd1
`endif
`ifndef EV_RIGHT
`define EV_RIGHT  3'd2
`endif
`ifndef EV_ROTATE
`define EV_ROTATE 3'd3
`endif
`ifndef EV_DOWN
`define EV_DOWN   3'd4
`endif
`ifndef EV_ENTER
`define EV_ENTER  3'd5
`endif
module game_event_scheduler #(
   parameter int DEPTH        = 4,
   parameter int GRAVITY_BASE = 25000000,
   parameter int GRAVITY_STEP = 2000000,
   parameter int GRAVITY_MIN  = 2500000,
   parameter int CNT_W        = 32
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [2:0]               key_event_i,
   input  logic                     key_event_valid_i,
   input  logic                     game_active_i,
   input  logic [3:0]               level_i,
   output logic [2:0]               user_event_o,
   output logic                     user_event_ready_o,
   input  logic                     user_event_rd_req_i,
   output logic [$clog2(DEPTH):0]   fifo_level_o,
   output logic [7:0]               key_drop_cnt_o
);
   localparam int AW = $clog2(DEPTH);
   logic [2:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr, rd_next;
   logic [AW:0] occ_after_pop, occ_next;
   logic [CNT_W-1:0] cnt, prod, diff, period;
   logic [2:0] wdata;
   logic pending, tick, pop, space, key_push, grav_push, push, resync;
   always_comb begin
      prod = CNT_W'(level_i) * CNT_W'(GRAVITY_STEP);
      diff = CNT_W'(GRAVITY_BASE) - prod;
      period = (prod > CNT_W'(GRAVITY_BASE) || diff < CNT_W'(GRAVITY_MIN)) ? CNT_W'(GRAVITY_MIN) : diff;
      tick = cnt >= period - CNT_W'(1);
      pop = user_event_rd_req_i && user_event_ready_o;
      space = (fifo_level_o < (AW+1)'(DEPTH)) || pop;
      key_push = key_event_valid_i && space;
      grav_push = !key_event_valid_i && pending && space;
      push = key_push || grav_push;
      wdata = key_event_valid_i ? key_event_i : `EV_DOWN;
      occ_after_pop = fifo_level_o - (AW+1)'(pop);
      occ_next = occ_after_pop + (AW+1)'(push);
      rd_next = rd_ptr + AW'(pop);
   end
`ifdef EVENT_SCHED_DOWN_RESYNC_EN
   assign resync = key_push && key_event_i == `EV_DOWN;
`else
   assign resync = 1'b0;
`endif
   always_ff @(posedge clk_i) begin
      if (push) mem[wr_ptr] <= wdata;
   end
   // Head register is loaded from the incoming word when the FIFO is empty after the pop.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt <= '0;
         pending <= 1'b0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         fifo_level_o <= '0;
         user_event_ready_o <= 1'b0;
         user_event_o <= 3'd0;
         key_drop_cnt_o <= 8'd0;
      end else begin
         if (!game_active_i || resync) begin
            cnt <= '0;
            pending <= 1'b0;
         end else begin
            cnt <= tick ? '0 : cnt + CNT_W'(1);
            pending <= tick || (pending && !grav_push);
         end
         if (push) wr_ptr <= wr_ptr + AW'(1);
         rd_ptr <= rd_next;
         fifo_level_o <= occ_next;
         user_event_ready_o <= occ_next != '0;
         if (occ_next != '0) user_event_o <= (occ_after_pop == '0) ? wdata : mem[rd_next];
         if (key_event_valid_i && !space && key_drop_cnt_o != 8'hFF) key_drop_cnt_o <= key_drop_cnt_o + 8'd1;
      end
   end
endmodule
